// File: rtl/ipv4_pkg.sv
// Shared constants, FSM encoding and ones'-complement arithmetic for the IPv4 header checker.
package ipv4_pkg;

    localparam logic [3:0] IPV4_VERSION = 4'd4;
    localparam logic [3:0] IHL_MIN      = 4'd5;
    localparam logic [3:0] IHL_MAX      = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // 16-bit add with end-around carry; a single fold suffices because
    // the folded value is at most 0xFFFF.
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum17;
        sum17 = {1'b0, a} + {1'b0, b};
        return sum17[15:0] + {15'd0, sum17[16]};
    endfunction

endpackage

// File: rtl/ones_comp_acc.sv
// 16-bit ones'-complement accumulator with synchronous clear and enable.
module ones_comp_acc
    import ipv4_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [15:0] din_i,
    output logic [15:0] sum_o
);

    logic [15:0] acc_q;
    logic [15:0] acc_d;

    // sum_o is what the accumulator becomes if din_i is accepted now.
    assign sum_o = ones_add(acc_q, din_i);

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum_o;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/ipv4_hdr_checksum.sv
// Streams an IPv4 header in 16-bit words, verifies its checksum and format,
// and holds the verdict on a valid/ready result port until taken.
module ipv4_hdr_checksum
    import ipv4_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              hdr_ok,
    output logic [15:0]       csum,
    output logic              err_version,
    output logic              err_ihl,
    output logic [CNT_W-1:0]  word_cnt
);

    state_e           state_q, state_d;
    logic [3:0]       ihl_q, ihl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             hdr_ok_q, hdr_ok_d;
    logic [15:0]      csum_q, csum_d;
    logic             err_version_q, err_version_d;
    logic             err_ihl_q, err_ihl_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    logic             acc_clr;
    logic             acc_en;
    logic [15:0]      acc_sum;
    logic             accept;
    logic             take;
    logic             last_word;
    logic             finish;

    ones_comp_acc u_acc (
        .clk   (clk),
        .reset (reset),
        .clr_i (acc_clr),
        .en_i  (acc_en),
        .din_i (in_data),
        .sum_o (acc_sum)
    );

    assign accept    = in_valid && in_ready_q;
    assign take      = out_valid_q && out_ready;
    assign last_word = (cnt_q + 1'b1) == CNT_W'({ihl_q, 1'b0});

    always_comb begin
        state_d       = state_q;
        ihl_d         = ihl_q;
        cnt_d         = cnt_q;
        out_valid_d   = out_valid_q;
        hdr_ok_d      = hdr_ok_q;
        csum_d        = csum_q;
        err_version_d = err_version_q;
        err_ihl_d     = err_ihl_q;
        word_cnt_d    = word_cnt_q;
        acc_clr       = 1'b0;
        acc_en        = 1'b0;
        finish        = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    // The accumulator is zero here, so adding the first word loads it.
                    ihl_d         = in_data[11:8];
                    err_version_d = (in_data[15:12] != IPV4_VERSION);
                    acc_en        = 1'b1;
                    cnt_d         = CNT_W'(1);
                    if (in_data[11:8] < IHL_MIN) begin
                        err_ihl_d = 1'b1;
                        finish    = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_en = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    finish = last_word;
                end
            end
            DONE: begin
                if (take) begin
                    state_d       = IDLE;
                    ihl_d         = '0;
                    cnt_d         = '0;
                    acc_clr       = 1'b1;
                    out_valid_d   = 1'b0;
                    hdr_ok_d      = 1'b0;
                    csum_d        = '0;
                    err_version_d = 1'b0;
                    err_ihl_d     = 1'b0;
                    word_cnt_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Result is captured from the sum that includes the word accepted this cycle.
        if (finish) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            csum_d      = ~acc_sum;
            hdr_ok_d    = (acc_sum == 16'hFFFF) && !err_version_d && !err_ihl_d;
            word_cnt_d  = cnt_d;
        end

        in_ready_d = (state_d != DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            ihl_q         <= '0;
            cnt_q         <= '0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            hdr_ok_q      <= 1'b0;
            csum_q        <= '0;
            err_version_q <= 1'b0;
            err_ihl_q     <= 1'b0;
            word_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            ihl_q         <= ihl_d;
            cnt_q         <= cnt_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            hdr_ok_q      <= hdr_ok_d;
            csum_q        <= csum_d;
            err_version_q <= err_version_d;
            err_ihl_q     <= err_ihl_d;
            word_cnt_q    <= word_cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign hdr_ok      = hdr_ok_q;
    assign csum        = csum_q;
    assign err_version = err_version_q;
    assign err_ihl     = err_ihl_q;
    assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_ipv4_hdr_checksum.sv
// Bench for ipv4_hdr_checksum: directed scenarios plus random headers against a folded-sum model.
module tb_ipv4_hdr_checksum;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        hdr_ok;
    logic [15:0] csum;
    logic        err_version;
    logic        err_ihl;
    logic [4:0]  word_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] hdr [0:31];
    logic        exp_ok, exp_ev, exp_ei;
    logic [15:0] exp_csum;
    int          exp_cnt;
    logic        ov_early;

    always #5 clk = ~clk;

    ipv4_hdr_checksum #(.DATA_W(16), .CNT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .hdr_ok      (hdr_ok),
        .csum        (csum),
        .err_version (err_version),
        .err_ihl     (err_ihl),
        .word_cnt    (word_cnt)
    );

    // Reference: header length from IHL, plain 32-bit sum folded to 16 bits.
    task automatic model();
        int unsigned s;
        int ihl;
        s   = 0;
        ihl = int'(hdr[0][11:8]);
        exp_cnt = (ihl < 5) ? 1 : 2 * ihl;
        for (int k = 0; k < exp_cnt; k++) s += hdr[k];
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        exp_ev   = (hdr[0][15:12] != 4'd4);
        exp_ei   = (ihl < 5);
        exp_csum = ~(16'(s));
        exp_ok   = (s == 32'hFFFF) && !exp_ev && !exp_ei;
    endtask

    task automatic load_reference();
        hdr[0] = 16'h4500; hdr[1] = 16'h0073; hdr[2] = 16'h0000; hdr[3] = 16'h4000;
        hdr[4] = 16'h4011; hdr[5] = 16'hB861; hdr[6] = 16'hC0A8; hdr[7] = 16'h0001;
        hdr[8] = 16'hC0A8; hdr[9] = 16'h00C7;
        for (int k = 10; k < 32; k++) hdr[k] = 16'(($urandom));
    endtask

    // Presents hdr[0..n-1]; a word counts once in_valid && in_ready precede an edge.
    task automatic drive_words(input int n, input bit toggle);
        int i;
        int cyc;
        bit phase;
        i = 0; cyc = 0; phase = 1'b0; ov_early = 1'b1;
        while (i < n && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (toggle && phase) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = hdr[i];
                if (in_ready) begin
                    if (i == n - 1) ov_early = out_valid;
                    i++;
                end
            end
            phase = !phase;
        end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (i != n) begin
            miscompares++;
            $display("FAIL drive_accept words_accepted=%0d required=%0d", i, n);
        end
    endtask

    task automatic take_result();
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #3;
        vectors++;
        if ({out_valid, hdr_ok, csum, err_version, err_ihl, word_cnt, in_ready} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h required=0", {out_valid, hdr_ok, csum, err_version, err_ihl, word_cnt, in_ready});
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready_low got=%b required=0", in_ready); end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_idle_ready got=%b required=1", in_ready); end
    endtask

    task automatic test_reference();
        load_reference();
        model();
        drive_words(10, 1'b0);
        vectors++;
        if (ov_early !== 1'b0) begin miscompares++; $display("FAIL ref_early_valid got=%b required=0", ov_early); end
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL ref_out_valid got=%b required=1", out_valid); end
        vectors++;
        if ({hdr_ok, csum, word_cnt} !== {1'b1, 16'h0000, 5'd10}) begin
            miscompares++;
            $display("FAIL ref_result got ok=%b csum=%h cnt=%0d required ok=1 csum=0000 cnt=10", hdr_ok, csum, word_cnt);
        end
        vectors++;
        if ({err_version, err_ihl} !== {exp_ev, exp_ei} || exp_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL ref_errors got=%b%b model_ok=%b required=00/1", err_version, err_ihl, exp_ok);
        end
        take_result();
    endtask

    task automatic test_bad_checksum();
        load_reference();
        hdr[5] = 16'hB862;
        model();
        drive_words(10, 1'b0);
        vectors++;
        if ({out_valid, hdr_ok, csum, err_version, err_ihl} !== {1'b1, 1'b0, 16'hFFFE, 2'b00}) begin
            miscompares++;
            $display("FAIL badsum_result got v=%b ok=%b csum=%h e=%b%b required v=1 ok=0 csum=fffe e=00", out_valid, hdr_ok, csum, err_version, err_ihl);
        end
        vectors++;
        if (csum !== exp_csum) begin miscompares++; $display("FAIL badsum_model got=%h required=%h", csum, exp_csum); end
        take_result();
    endtask

    task automatic test_ihl_short();
        load_reference();
        hdr[0] = 16'h4400;
        model();
        drive_words(1, 1'b0);
        vectors++;
        if ({out_valid, err_ihl, err_version, hdr_ok, word_cnt, csum} !== {4'b1100, 5'd1, exp_csum}) begin
            miscompares++;
            $display("FAIL ihl_result got v=%b ei=%b ev=%b ok=%b cnt=%0d csum=%h required 1/1/0/0 cnt=1 csum=%h",
                     out_valid, err_ihl, err_version, hdr_ok, word_cnt, csum, exp_csum);
        end
        in_valid = 1'b1; in_data = hdr[1];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0 || word_cnt !== 5'd1) begin
                miscompares++;
                $display("FAIL ihl_hold got ready=%b cnt=%0d required ready=0 cnt=1", in_ready, word_cnt);
            end
        end
        in_valid = 1'b0;
        take_result();
    endtask

    task automatic test_version();
        load_reference();
        hdr[0] = 16'h6500;
        model();
        drive_words(10, 1'b0);
        vectors++;
        if ({out_valid, err_version, err_ihl, hdr_ok, word_cnt, csum} !== {4'b1100, 5'd10, exp_csum}) begin
            miscompares++;
            $display("FAIL ver_result got v=%b ev=%b ei=%b ok=%b cnt=%0d csum=%h required 1/1/0/0 cnt=10 csum=%h",
                     out_valid, err_version, err_ihl, hdr_ok, word_cnt, csum, exp_csum);
        end
        in_valid = 1'b1; in_data = hdr[10];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0 || word_cnt !== 5'd10) begin
                miscompares++;
                $display("FAIL ver_extra_word got ready=%b cnt=%0d required ready=0 cnt=10", in_ready, word_cnt);
            end
        end
        in_valid = 1'b0;
        take_result();
    endtask

    task automatic test_stall();
        load_reference();
        model();
        drive_words(10, 1'b1);
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if ({out_valid, hdr_ok, csum, word_cnt, err_version, err_ihl, in_ready} !== {2'b11, 16'h0000, 5'd10, 3'b000}) begin
                miscompares++;
                $display("FAIL stall_hold cycle=%0d got v=%b ok=%b csum=%h cnt=%0d e=%b%b rdy=%b", c, out_valid, hdr_ok, csum,
                         word_cnt, err_version, err_ihl, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1; in_data = hdr[0];
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_take_ready got=%b required=0", in_ready); end
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || word_cnt !== 5'd0) begin
            miscompares++;
            $display("FAIL stall_after_take got rdy=%b v=%b cnt=%0d required rdy=1 v=0 cnt=0", in_ready, out_valid, word_cnt);
        end
    endtask

    task automatic test_reset_mid();
        load_reference();
        hdr[0] = 16'h6500;
        drive_words(4, 1'b0);
        vectors++;
        if (err_version !== 1'b1 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_before got ev=%b rdy=%b required ev=1 rdy=1", err_version, in_ready);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({out_valid, hdr_ok, csum, err_version, err_ihl, word_cnt, in_ready} !== '0) begin
            miscompares++;
            $display("FAIL midrst_async got=%h required=0", {out_valid, hdr_ok, csum, err_version, err_ihl, word_cnt, in_ready});
        end
        @(negedge clk);
        reset = 1'b1;
        load_reference();
        model();
        drive_words(10, 1'b0);
        vectors++;
        if ({out_valid, hdr_ok, csum, word_cnt} !== {2'b11, 16'h0000, 5'd10}) begin
            miscompares++;
            $display("FAIL midrst_fresh got v=%b ok=%b csum=%h cnt=%0d required v=1 ok=1 csum=0000 cnt=10", out_valid, hdr_ok, csum, word_cnt);
        end
        take_result();
    endtask

    task automatic test_random();
        int unsigned s;
        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < 32; k++) hdr[k] = 16'($urandom);
            hdr[0][15:12] = ($urandom_range(0, 3) == 0) ? 4'(($urandom)) : 4'd4;
            hdr[0][11:8]  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(5, 15));
            if (hdr[0][11:8] >= 4'd5 && $urandom_range(0, 1) == 1) begin
                hdr[5] = 16'h0000;
                s = 0;
                for (int k = 0; k < 2 * int'(hdr[0][11:8]); k++) s += hdr[k];
                while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
                hdr[5] = ~(16'(s));
            end
            model();
            drive_words(exp_cnt, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            vectors++;
            if ({out_valid, hdr_ok, csum, err_version, err_ihl, word_cnt} !== {1'b1, exp_ok, exp_csum, exp_ev, exp_ei, 5'(exp_cnt)}) begin
                miscompares++;
                $display("FAIL rand_%0d got v=%b ok=%b csum=%h ev=%b ei=%b cnt=%0d required v=1 ok=%b csum=%h ev=%b ei=%b cnt=%0d",
                         t, out_valid, hdr_ok, csum, err_version, err_ihl, word_cnt, exp_ok, exp_csum, exp_ev, exp_ei, exp_cnt);
            end
            take_result();
        end
    endtask

    initial begin
        test_reset();
        test_reference();
        test_bad_checksum();
        test_ihl_short();
        test_version();
        test_stall();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
